// File: rtl/gmii_tx_frame_receiver_if.sv
// Byte-wide payload stream leaving the GMII TX frame receiver.
// A beat transfers on every cycle where tvalid is high. There is no tready, so the sink must accept each beat.
interface gmii_tx_frame_receiver_if;
  logic [7:0] tdata;
  logic       tkeep;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/gmii_tx_frame_receiver.sv
// Strips preamble/SFD from the MAC's GMII TX stream, checks and removes the FCS, and emits frames as AXI-stream bytes.
// Optional inter-frame-gap checker is built when GMII_TX_IFG_CHECK_EN is defined.
module gmii_tx_frame_receiver #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1518,
  parameter int MIN_IFG          = 12
) (
  input  logic                            clock125,
  input  logic                            reset,
  input  logic [7:0]                      gmii_txd,
  input  logic                            gmii_tx_en,
  input  logic                            gmii_tx_er,
  gmii_tx_frame_receiver_if.master        m_axis,
  output logic                            frame_good,
  output logic                            frame_bad,
  output logic                            preamble_error,
  output logic                            ifg_violation,
  output logic [31:0]                     good_frame_count,
  output logic [31:0]                     bad_frame_count,
  output logic [1:0]                      state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2, DROP = 2'd3} state_t;

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LENGTH);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LENGTH);

  state_t      state, state_next;
  logic [2:0]  pre_cnt;
  logic [39:0] dline;
  logic [2:0]  dl_cnt;
  logic [31:0] crc;
  logic [10:0] len;
  logic        er_seen;

  logic pre_err, start_frame, data_beat, end_frame;
  logic emit, runt, frame_is_bad, good_next, bad_next;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction

  always_ff @(posedge clock125) begin
    if (reset) state <= DROP;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pre_err     = 1'b0;
    start_frame = 1'b0;
    data_beat   = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_tx_en) begin
          if (gmii_txd == 8'h55) state_next = PREAMBLE;
          else begin
            pre_err    = 1'b1;
            state_next = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_tx_en) begin
          pre_err    = 1'b1;
          state_next = IDLE;
        end else if (gmii_txd == 8'hD5) begin
          start_frame = 1'b1;
          state_next  = DATA;
        end else if (gmii_txd == 8'h55 && pre_cnt != 3'd7) begin
          state_next = PREAMBLE;
        end else begin
          pre_err    = 1'b1;
          state_next = DROP;
        end
      end
      DATA: begin
        if (gmii_tx_en) data_beat = 1'b1;
        else begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end
      end
      DROP: begin
        if (!gmii_tx_en) state_next = IDLE;
      end
      default: state_next = DROP;
    endcase
  end

  // The newest four held bytes are the FCS, so a byte is only released once four more sit behind it.
  assign emit         = (data_beat || end_frame) && (dl_cnt == 3'd5);
  assign runt         = end_frame && (dl_cnt != 3'd5);
  assign frame_is_bad = (crc != 32'hDEBB_20E3) || er_seen || (len < MIN_LEN) || (len > MAX_LEN);
  assign good_next    = emit && end_frame && !frame_is_bad;
  assign bad_next     = pre_err || runt || (emit && end_frame && frame_is_bad);

  assign state_dbg    = state;
  assign m_axis.tkeep = 1'b1;

  always_ff @(posedge clock125) begin
    if (reset) begin
      pre_cnt          <= 3'd0;
      dline            <= 40'h0;
      dl_cnt           <= 3'd0;
      crc              <= 32'hFFFF_FFFF;
      len              <= 11'd0;
      er_seen          <= 1'b0;
      m_axis.tdata     <= 8'h00;
      m_axis.tvalid    <= 1'b0;
      m_axis.tlast     <= 1'b0;
      m_axis.tuser     <= 1'b0;
      frame_good       <= 1'b0;
      frame_bad        <= 1'b0;
      preamble_error   <= 1'b0;
      good_frame_count <= 32'd0;
      bad_frame_count  <= 32'd0;
    end else begin
      if (state_next == PREAMBLE)
        pre_cnt <= (state == IDLE) ? 3'd1 : pre_cnt + 3'd1;

      if (start_frame) begin
        dl_cnt  <= 3'd0;
        crc     <= 32'hFFFF_FFFF;
        len     <= 11'd0;
        er_seen <= gmii_tx_er;
      end else if (data_beat) begin
        dline   <= {dline[31:0], gmii_txd};
        crc     <= crc32_byte(crc, gmii_txd);
        er_seen <= er_seen | gmii_tx_er;
        if (dl_cnt != 3'd5) dl_cnt <= dl_cnt + 3'd1;
        if (len != 11'h7FF) len <= len + 11'd1;
      end

      m_axis.tvalid    <= emit;
      m_axis.tdata     <= emit ? dline[39:32] : 8'h00;
      m_axis.tlast     <= emit && end_frame;
      m_axis.tuser     <= emit && end_frame && frame_is_bad;
      frame_good       <= good_next;
      frame_bad        <= bad_next;
      preamble_error   <= pre_err;
      good_frame_count <= good_frame_count + {31'd0, good_next};
      bad_frame_count  <= bad_frame_count + {31'd0, bad_next};
    end
  end

`ifdef GMII_TX_IFG_CHECK_EN
  localparam logic [7:0] IFG_MIN = 8'(MIN_IFG);

  logic [7:0] idle_cnt;
  logic       tx_en_d;
  logic       seen_frame;

  // seen_frame exempts the first frame after reset, whose preceding gap is unknown.
  always_ff @(posedge clock125) begin
    if (reset) begin
      idle_cnt      <= 8'd0;
      tx_en_d       <= 1'b0;
      seen_frame    <= 1'b0;
      ifg_violation <= 1'b0;
    end else begin
      tx_en_d       <= gmii_tx_en;
      ifg_violation <= gmii_tx_en && !tx_en_d && seen_frame && (idle_cnt < IFG_MIN);
      if (gmii_tx_en) begin
        idle_cnt   <= 8'd0;
        seen_frame <= 1'b1;
      end else if (idle_cnt != 8'hFF) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end
`else
  // Without the checker the flag is held low; the comparison is false for any legal gap limit.
  assign ifg_violation = (MIN_IFG < 0);
`endif
endmodule

// File: tb/tb_gmii_tx_frame_receiver.sv
// Directed bench for gmii_tx_frame_receiver: drives GMII frames and scores the AXI-stream beats, pulses and counters.
`timescale 1ns/1ps
module tb_gmii_tx_frame_receiver;
  // clock / reset
  logic        clock125 = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  gmii_txd = 8'h00;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_er = 1'b0;
  logic        frame_good, frame_bad, preamble_error, ifg_violation;
  logic [31:0] good_frame_count, bad_frame_count;
  logic [1:0]  state_dbg;
  int          cyc = 0;

  always #4 clock125 = ~clock125;
  always @(posedge clock125) cyc <= cyc + 1;

  gmii_tx_frame_receiver_if m_axis_if ();

  gmii_tx_frame_receiver dut (
    .clock125         (clock125),
    .reset            (reset),
    .gmii_txd         (gmii_txd),
    .gmii_tx_en       (gmii_tx_en),
    .gmii_tx_er       (gmii_tx_er),
    .m_axis           (m_axis_if),
    .frame_good       (frame_good),
    .frame_bad        (frame_bad),
    .preamble_error   (preamble_error),
    .ifg_violation    (ifg_violation),
    .good_frame_count (good_frame_count),
    .bad_frame_count  (bad_frame_count),
    .state_dbg        (state_dbg)
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] fr_q[$];
  int  errors = 0, checks = 0;
  bit  exp_tuser = 1'b0;
  int  exp_good = 0, exp_bad = 0;
  int  beats = 0, lasts = 0, good_p = 0, bad_p = 0, pre_p = 0, ifg_p = 0;
  int  s_beats, s_lasts, s_good, s_bad, s_pre, s_ifg;
  int  first_cyc = 0, first_beat_cyc = 0;
  bit  frame_open = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clock125) begin
    logic [31:0] exp_b;
    if (m_axis_if.tvalid === 1'b1) begin
      if (!frame_open) begin
        first_beat_cyc = cyc;
        frame_open     = 1'b1;
      end
      exp_b = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
      check("beat_data", {24'h0, m_axis_if.tdata}, exp_b);
      check("beat_tkeep", m_axis_if.tkeep, 1);
      check("beat_tlast", m_axis_if.tlast, exp_q.size() == 0);
      beats++;
      if (m_axis_if.tlast === 1'b1) begin
        lasts++;
        frame_open = 1'b0;
        check("last_tuser", m_axis_if.tuser, exp_tuser);
        check("last_good_pulse", frame_good, !exp_tuser);
        check("last_bad_pulse", frame_bad, exp_tuser);
      end else begin
        check("mid_pulses", {frame_good, frame_bad}, 0);
      end
    end
    if (frame_good === 1'b1) good_p++;
    if (frame_bad === 1'b1) bad_p++;
    if (preamble_error === 1'b1) begin
      pre_p++;
      check("pre_with_bad", frame_bad, 1);
    end
    if (ifg_violation === 1'b1) ifg_p++;
    if (reset) frame_open = 1'b0;
  end

  // driver tasks
  task automatic tick(input logic en, input logic [7:0] d, input logic er);
    gmii_tx_en = en;
    gmii_txd   = d;
    gmii_tx_er = er;
    @(posedge clock125);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic build_frame(input int n, input logic [7:0] fcs_xor);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    fr_q = {};
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      fr_q.push_back(b);
      for (int k = 0; k < 8; k++)
        c = (c >> 1) ^ (((c[0] ^ b[k]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
    end
    fcs = ~c;
    fr_q.push_back(fcs[7:0]);
    fr_q.push_back(fcs[15:8]);
    fr_q.push_back(fcs[23:16]);
    fr_q.push_back(fcs[31:24] ^ fcs_xor);
  endtask

  task automatic send_frame(input int pre_len, input int er_idx, input int rst_idx, input bit push);
    int n;
    n = fr_q.size();
    for (int i = 0; i < pre_len; i++) tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (push && i < n - 4) exp_q.push_back(fr_q[i]);
      if (i == 0) first_cyc = cyc + 1;
      reset = (i == rst_idx);
      tick(1'b1, fr_q[i], i == er_idx);
    end
    reset = 1'b0;
  endtask

  task automatic snap();
    s_beats = beats; s_lasts = lasts; s_good = good_p;
    s_bad = bad_p; s_pre = pre_p; s_ifg = ifg_p;
  endtask

  task automatic expect_frame(input string tag, input int d_beats, input int d_lasts,
                              input int d_good, input int d_bad, input int d_pre);
    check({tag, "_beats"}, beats - s_beats, d_beats);
    check({tag, "_lasts"}, lasts - s_lasts, d_lasts);
    check({tag, "_good_pulses"}, good_p - s_good, d_good);
    check({tag, "_bad_pulses"}, bad_p - s_bad, d_bad);
    check({tag, "_pre_pulses"}, pre_p - s_pre, d_pre);
    check({tag, "_good_count"}, good_frame_count, exp_good);
    check({tag, "_bad_count"}, bad_frame_count, exp_bad);
    check({tag, "_exp_q_drained"}, exp_q.size(), 0);
  endtask

  // directed sequence
  initial begin
    reset = 1'b1;
    idle(3);
    check("rst_tvalid", m_axis_if.tvalid, 0);
    check("rst_tlast", m_axis_if.tlast, 0);
    check("rst_tuser", m_axis_if.tuser, 0);
    check("rst_pulses", {frame_good, frame_bad, preamble_error, ifg_violation}, 0);
    check("rst_good_count", good_frame_count, 0);
    check("rst_bad_count", bad_frame_count, 0);
    reset = 1'b0;
    idle(4);

    // good 60-byte payload frame
    exp_tuser = 1'b0; build_frame(60, 8'h00); snap();
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_good++;
    expect_frame("t1_good", 60, 1, 1, 0, 0);
    check("t1_latency", first_beat_cyc - first_cyc, 5);

    // corrupted FCS
    exp_tuser = 1'b1; build_frame(60, 8'h01); snap();
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_bad++;
    expect_frame("t2_bad_fcs", 60, 1, 0, 1, 0);

    // tx_er for one cycle at byte 20
    exp_tuser = 1'b1; build_frame(60, 8'h00); snap();
    send_frame(7, 20, -1, 1'b1); idle(16);
    exp_bad++;
    expect_frame("t3_tx_er", 60, 1, 0, 1, 0);

    // runt: 3 bytes after SFD
    fr_q = {8'hAA, 8'hBB, 8'hCC}; snap();
    send_frame(7, -1, -1, 1'b0); idle(16);
    exp_bad++;
    expect_frame("t3_runt", 0, 0, 0, 1, 0);

    // bad preamble byte 0x57
    snap();
    tick(1'b1, 8'h55, 1'b0); tick(1'b1, 8'h55, 1'b0); tick(1'b1, 8'h57, 1'b0);
    repeat (10) tick(1'b1, 8'h11, 1'b0);
    idle(16);
    exp_bad++;
    expect_frame("t4_bad_pre", 0, 0, 0, 1, 1);

    exp_tuser = 1'b0; build_frame(60, 8'h00); snap();
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_good++;
    expect_frame("t4_recover", 60, 1, 1, 0, 0);

    // eight preamble bytes
    snap();
    send_frame(8, -1, -1, 1'b0); idle(16);
    exp_bad++;
    expect_frame("t4_long_pre", 0, 0, 0, 1, 1);

    // 63 bytes DA..FCS is one below the minimum
    exp_tuser = 1'b1; build_frame(59, 8'h00); snap();
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_bad++;
    expect_frame("min_minus1", 59, 1, 0, 1, 0);

    // 1518 bytes (max) with a one-byte preamble, then 1519
    exp_tuser = 1'b0; build_frame(1514, 8'h00); snap();
    send_frame(1, -1, -1, 1'b1); idle(16);
    exp_good++;
    expect_frame("max_len", 1514, 1, 1, 0, 0);

    exp_tuser = 1'b1; build_frame(1515, 8'h00); snap();
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_bad++;
    expect_frame("max_plus1", 1515, 1, 0, 1, 0);

    // reset pulsed at payload byte 30
    exp_tuser = 1'b0; build_frame(60, 8'h00); snap();
    send_frame(7, -1, 30, 1'b1); idle(16);
    exp_q.delete();
    exp_good = 0; exp_bad = 0;
    expect_frame("t5_abort", 25, 0, 0, 0, 0);

    snap();
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_good++;
    expect_frame("t5_after", 60, 1, 1, 0, 0);

`ifdef GMII_TX_IFG_CHECK_EN
    exp_tuser = 1'b0; build_frame(60, 8'h00); snap();
    send_frame(7, -1, -1, 1'b1); idle(8);
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_good += 2;
    expect_frame("t6_gap8", 120, 2, 2, 0, 0);
    check("t6_ifg_gap8", ifg_p - s_ifg, 1);

    snap();
    send_frame(7, -1, -1, 1'b1); idle(12);
    send_frame(7, -1, -1, 1'b1); idle(16);
    exp_good += 2;
    expect_frame("t6_gap12", 120, 2, 2, 0, 0);
    check("t6_ifg_gap12", ifg_p - s_ifg, 0);
`else
    check("no_ifg_pulses", ifg_p, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
